mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
- Shares one byte-wide, big-endian 512x8 memory between the instruction-fetch port (word reads) and the data port (byte/half/word loads and stores with optional sign extension).
- Serialises each multi-byte access into one byte per cycle and returns the assembled result with a single-cycle acknowledge.
- Sits between the fetch/load-store stages and the unified memory array.

Parameters:
- ADDR_W, 9, byte-address width; memory depth is 2^ADDR_W.
- ROUND_ROBIN, 1, arbitration mode: 1 = alternate grants on a tie; 0 = data port has fixed priority.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- IReq  in  1  fetch request; held until IAck.
- IAddr  in  ADDR_W  fetch byte address (MSB byte).
- IData  out  32  fetched word; valid while IAck=1, held afterwards.
- IAck  out  1  one-cycle fetch completion pulse.
- DReq  in  1  data request; held until DAck.
- DReadWrite  in  1  1 = store, 0 = load.
- DSize  in  2  00 = byte, 01 = half, 10 or 11 = word.
- DSignExtend  in  1  load sign extension.
- DAddr  in  ADDR_W  data byte address (MSB byte).
- DDataIn  in  32  store data, right-justified.
- DDataOut  out  32  load result; valid while DAck=1, held afterwards.
- DAck  out  1  one-cycle data completion pulse.
- MemAddr  out  ADDR_W  memory byte address.
- MemWData  out  8  memory write byte.
- MemWE  out  1  memory byte write enable.
- MemRData  in  8  memory read byte; combinational from MemAddr.
- Busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset values: all outputs are 0, state is IDLE, and LastGrant is set to I, so the data port wins the first tie.
- State machine has three states: IDLE, XFER and DONE.
- IDLE:
  - If exactly one Req is high, grant that port.
  - If both are high and ROUND_ROBIN=1, grant the port that is not LastGrant.
  - If both are high and ROUND_ROBIN=0, grant D.
  - On grant, latch the granted port's address, size, direction, sign-extend and store data; set Count=0 and N; go to XFER.
  - N is 4 for fetch, or 1/2/4 from DSize.
- XFER:
  - MemAddr = (base + Count) mod 2^ADDR_W; wrap-around is allowed and not flagged.
  - Loads/fetches: shift MemRData into the assembly register. Byte 0 is the MSB of the N-byte result.
  - Stores: MemWE=1 and MemWData = latched store byte (N-1-Count) of the right-justified data, so the MSB goes to the base address.
  - Count increments each cycle; when Count=N-1, go to DONE.
- DONE:
  - Assert the granted port's Ack for exactly one cycle and update LastGrant.
  - Load result: zero-extend, or sign-extend from bit 7 (byte) / bit 15 (half) when DSignExtend=1; word loads are never extended.
  - Fetch result goes to IData. Store acks leave DDataOut unchanged.
  - Next state is IDLE.
- Latency: Req sampled at edge t in IDLE, then XFER occupies cycles t+1..t+N and Ack is high in cycle t+N+1. Word = 6 cycles request-to-ack, byte = 3.
- MemWE is 0 outside XFER-store cycles. MemAddr and MemWData are 0 in IDLE.
- Request inputs changing after grant are ignored. The ungranted port waits with no Ack.
- A Req still high in the IDLE cycle after its Ack starts a new transaction; requesters must drop Req on the Ack cycle.
- Reset mid-XFER: return to IDLE next edge, no Ack, MemWE=0. Bytes already written stay in memory.

Test Plan:
- Fetch only: mem[0x10..0x13]=12 34 56 78, IReq at IAddr=0x10 -> IAck in cycle 6 after request, IData=0x12345678, MemWE=0 throughout.
- Data byte loads: mem[0x20]=0x85, DSize=00:
  - DSignExtend=1 -> DDataOut=0xFFFFFF85 three cycles after request.
  - DSignExtend=0 -> DDataOut=0x00000085.
- Half store then word load:
  - Store 0x0000BEEF, DSize=01 at 0x40 -> MemWE two cycles, mem[0x40]=BE, mem[0x41]=EF.
  - Word load at 0x40 (mem[0x42..0x43] preloaded 00 00) -> 0xBEEF0000.
- Simultaneous IReq and DReq held continuously, ROUND_ROBIN=1 -> grants alternate D, I, D, I; with ROUND_ROBIN=0 -> D granted every time DReq is high.
- Wrap: word fetch at IAddr=0x1FE -> MemAddr sequence 1FE, 1FF, 000, 001; result assembled in that order.
- Reset asserted during the third XFER cycle of a word store at 0x80 -> no DAck, MemWE=0 next cycle, mem[0x80..0x81] updated, mem[0x82..0x83] unchanged, Busy=0.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one byte-wide, big-endian memory between an instruction-fetch port
//   (word reads) and a data port (byte/half/word loads and stores). Every
//   access is serialised into one memory byte per cycle. The assembled result
//   is returned with a one-cycle acknowledge.
//
// Ports
//   clk, reset          rising-edge clock, synchronous active-high reset
//   IReq/IAddr          fetch request and byte address (MSB byte first)
//   IData/IAck          fetched word (held after the ack) and completion pulse
//   DReq/DReadWrite     data request, 1 = store / 0 = load
//   DSize/DSignExtend   00 byte, 01 half, 1x word; sign extension for loads
//   DAddr/DDataIn       data byte address, right-justified store data
//   DDataOut/DAck       load result (held after the ack) and completion pulse
//   MemAddr/MemWData    memory byte address and write byte
//   MemWE/MemRData      byte write enable, combinational read byte
//   Busy                high whenever the arbiter is not idle
module mem_port_arbiter #(
  parameter int ADDR_W      = 9,
  parameter bit ROUND_ROBIN = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              IReq,
  input  logic [ADDR_W-1:0] IAddr,
  output logic [31:0]       IData,
  output logic              IAck,
  input  logic              DReq,
  input  logic              DReadWrite,
  input  logic [1:0]        DSize,
  input  logic              DSignExtend,
  input  logic [ADDR_W-1:0] DAddr,
  input  logic [31:0]       DDataIn,
  output logic [31:0]       DDataOut,
  output logic              DAck,
  output logic [ADDR_W-1:0] MemAddr,
  output logic [7:0]        MemWData,
  output logic              MemWE,
  input  logic [7:0]        MemRData,
  output logic              Busy
);

  typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;

  state_t            state_reg, state_next;
  logic              grant_d_reg;   // 1 = data port owns the transaction
  logic              last_d_reg;    // 1 = last completed grant was the data port
  logic [ADDR_W-1:0] base_reg;
  logic [2:0]        n_reg;         // bytes in this transaction: 1, 2 or 4
  logic [2:0]        count_reg;
  logic              write_reg;
  logic              sext_reg;
  logic [31:0]       wdata_reg;
  logic [31:0]       asm_reg;
  logic [31:0]       idata_reg;
  logic [31:0]       ddata_reg;

  logic              pick_d;
  logic              last_byte;
  logic [31:0]       asm_shift;
  logic [31:0]       load_ext;
  logic [2:0]        byte_idx;
  logic [31:0]       wdata_shift;
  logic [2:0]        dsize_n;

  // Data wins unless fetch is also requesting and round-robin says it is
  // fetch's turn (the data port was granted last).
  assign pick_d    = DReq && (!IReq || !ROUND_ROBIN || !last_d_reg);
  assign last_byte = (count_reg == n_reg - 3'd1);
  assign dsize_n   = (DSize == 2'b00) ? 3'd1 : (DSize == 2'b01) ? 3'd2 : 3'd4;

  // The assembly register is cleared at grant, so after N shifts the bytes
  // are right-justified with zeros above them (zero extension comes free).
  assign asm_shift = {asm_reg[23:0], MemRData};

  always_comb begin
    load_ext = asm_shift;
    if (sext_reg && n_reg == 3'd1)
      load_ext = {{24{asm_shift[7]}}, asm_shift[7:0]};
    else if (sext_reg && n_reg == 3'd2)
      load_ext = {{16{asm_shift[15]}}, asm_shift[15:0]};
  end

  // Store bytes go out MSB first: byte (N-1-Count) of the right-justified data.
  assign byte_idx    = n_reg - 3'd1 - count_reg;
  assign wdata_shift = wdata_reg >> {byte_idx[1:0], 3'b000};

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (IReq || DReq) state_next = XFER;
      XFER:    if (last_byte)    state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    MemAddr  = '0;
    MemWData = 8'h00;
    MemWE    = 1'b0;
    IAck     = 1'b0;
    DAck     = 1'b0;
    Busy     = (state_reg != IDLE);
    case (state_reg)
      XFER: begin
        MemAddr = base_reg + ADDR_W'(count_reg);
        if (write_reg) begin
          // Gated by reset so a store aborted by reset writes nothing
          // further in the cycle reset is asserted.
          MemWE    = !reset;
          MemWData = wdata_shift[7:0];
        end
      end
      DONE: begin
        IAck = !grant_d_reg;
        DAck = grant_d_reg;
      end
      default: ;
    endcase
  end

  assign IData    = idata_reg;
  assign DDataOut = ddata_reg;

  // Datapath: grant latching, byte counting, assembly and result registers
  always_ff @(posedge clk) begin
    if (reset) begin
      grant_d_reg <= 1'b0;
      last_d_reg  <= 1'b0;
      base_reg    <= '0;
      n_reg       <= 3'd0;
      count_reg   <= 3'd0;
      write_reg   <= 1'b0;
      sext_reg    <= 1'b0;
      wdata_reg   <= 32'h0;
      asm_reg     <= 32'h0;
      idata_reg   <= 32'h0;
      ddata_reg   <= 32'h0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (IReq || DReq) begin
            grant_d_reg <= pick_d;
            count_reg   <= 3'd0;
            asm_reg     <= 32'h0;
            if (pick_d) begin
              base_reg  <= DAddr;
              n_reg     <= dsize_n;
              write_reg <= DReadWrite;
              sext_reg  <= DSignExtend;
              wdata_reg <= DDataIn;
            end else begin
              base_reg  <= IAddr;
              n_reg     <= 3'd4;
              write_reg <= 1'b0;
              sext_reg  <= 1'b0;
              wdata_reg <= 32'h0;
            end
          end
        end
        XFER: begin
          count_reg <= count_reg + 3'd1;
          asm_reg   <= asm_shift;
          // Results are captured as the last byte arrives so they are
          // already stable during the ack cycle.
          if (last_byte && !write_reg) begin
            if (grant_d_reg) ddata_reg <= load_ext;
            else             idata_reg <= asm_shift;
          end
        end
        DONE: last_d_reg <= grant_d_reg;
        default: ;
      endcase
    end
  end

endmodule
